line_buffer: RTL and testbench

LINE_BUFFER -- requirements
Module: line_buffer

---
 rtl/line_buffer_pkg.sv | 16 +
 rtl/line_buffer_if.sv | 35 +++
 rtl/line_buffer_datapath.sv | 73 +++++++
 rtl/line_buffer.sv | 122 ++++++++++++
 tb/tb_line_buffer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/line_buffer_pkg.sv
// Shared types and sizing for the single-line buffer between a 32-bit CPU port
// and a 64-bit burst memory port.
package line_buffer_types;

  localparam int unsigned BEATS     = 4;
  localparam int unsigned LINE_BITS = 256;
  localparam int unsigned TAG_BITS  = 27;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    RESP
  } state_e;

endpackage

// File: rtl/line_buffer_if.sv
// CPU-side word port and memory-side burst port of the line buffer.
interface line_buffer_if;

  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  logic [31:0] pmem_address;
  logic        pmem_read;
  logic        pmem_write;
  logic [63:0] pmem_rdata;
  logic [63:0] pmem_wdata;
  logic        pmem_resp;

  // The line buffer itself.
  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp,
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  // The surrounding system: CPU plus burst memory.
  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp,
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/line_buffer_datapath.sv
// Line storage: 256-bit data, tag, valid and dirty, with beat fill and CPU byte merge.
module line_buffer_datapath #(
  parameter int unsigned LINE_BITS = line_buffer_types::LINE_BITS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fill_we,
  input  logic [1:0]  beat_sel,
  input  logic [63:0] fill_data,
  input  logic        fill_done,
  input  logic [26:0] fill_tag,
  input  logic        clear_dirty,
  input  logic        cpu_we,
  input  logic [2:0]  word_sel,
  input  logic [3:0]  byte_enable,
  input  logic [31:0] wdata,
  output logic [26:0] tag,
  output logic        valid,
  output logic        dirty,
  output logic [31:0] rdata_word,
  output logic [63:0] beat_data
);
  import line_buffer_types::*;

  logic [LINE_BITS-1:0] data_q, data_d;
  logic [TAG_BITS-1:0]  tag_q;
  logic                 valid_q, dirty_q;

  always_comb begin
    data_d = data_q;
    if (fill_we) begin
      data_d[64*beat_sel +: 64] = fill_data;
    end
    if (cpu_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_enable[b]) begin
          data_d[32*word_sel + 8*b +: 8] = wdata[8*b +: 8];
        end
      end
    end
  end

  // Line contents are meaningless until valid is set, so they carry no reset.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    if (fill_done) begin
      tag_q <= fill_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
    end else begin
      if (fill_done) begin
        valid_q <= 1'b1;
      end
      if (clear_dirty || fill_done) begin
        dirty_q <= 1'b0;
      end else if (cpu_we) begin
        dirty_q <= 1'b1;
      end
    end
  end

  assign tag        = tag_q;
  assign valid      = valid_q;
  assign dirty      = dirty_q;
  assign rdata_word = data_q[32*word_sel +: 32];
  assign beat_data  = data_q[64*beat_sel +: 64];

endmodule

// File: rtl/line_buffer.sv
// Single-line write-back buffer: hit/miss control, writeback and fill bursts, CPU response.
module line_buffer #(
  parameter int unsigned BEATS     = line_buffer_types::BEATS,
  parameter int unsigned LINE_BITS = line_buffer_types::LINE_BITS
) (
  input  logic         clk,
  input  logic         rst,
  line_buffer_if.slave bus
);
  import line_buffer_types::*;

  localparam logic [1:0] LastBeat = 2'(BEATS - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;

  logic        fill_we, fill_done, clear_dirty, cpu_we;
  logic [26:0] tag;
  logic        valid, dirty;
  logic [31:0] rdata_word;
  logic [63:0] beat_data;
  logic        req, hit;

  assign req = bus.mem_read | bus.mem_write;
  assign hit = valid && (tag == bus.mem_address[31:5]);

  line_buffer_datapath #(
    .LINE_BITS (LINE_BITS)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .fill_we     (fill_we),
    .beat_sel    (cnt_q),
    .fill_data   (bus.pmem_rdata),
    .fill_done   (fill_done),
    .fill_tag    (bus.mem_address[31:5]),
    .clear_dirty (clear_dirty),
    .cpu_we      (cpu_we),
    .word_sel    (bus.mem_address[4:2]),
    .byte_enable (bus.mem_byte_enable),
    .wdata       (bus.mem_wdata),
    .tag         (tag),
    .valid       (valid),
    .dirty       (dirty),
    .rdata_word  (rdata_word),
    .beat_data   (beat_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    fill_we          = 1'b0;
    fill_done        = 1'b0;
    clear_dirty      = 1'b0;
    cpu_we           = 1'b0;
    bus.mem_resp     = 1'b0;
    bus.mem_rdata    = '0;
    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          cnt_d = 2'd0;
          if (hit) begin
            state_d = RESP;
          end else if (valid && dirty) begin
            state_d = WB;
          end else begin
            state_d = FILL;
          end
        end
      end
      WB: begin
        bus.pmem_write   = 1'b1;
        bus.pmem_address = {tag, 5'b0};
        bus.pmem_wdata   = beat_data;
        if (bus.pmem_resp) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == LastBeat) begin
            clear_dirty = 1'b1;
            cnt_d       = 2'd0;
            state_d     = FILL;
          end
        end
      end
      FILL: begin
        bus.pmem_read    = 1'b1;
        bus.pmem_address = {bus.mem_address[31:5], 5'b0};
        if (bus.pmem_resp) begin
          fill_we = 1'b1;
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == LastBeat) begin
            fill_done = 1'b1;
            state_d   = RESP;
          end
        end
      end
      RESP: begin
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = rdata_word;
        // A simultaneous read+write request is a write.
        cpu_we        = bus.mem_write;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_line_buffer.sv
// Self-checking bench for line_buffer: directed vector table, reset/stall sequences,
// and randomized traffic against a flat word-memory reference.
module tb_line_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  line_buffer_if bus ();

  line_buffer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Burst memory model state.
  int  rd_total = 0, wr_total = 0;
  int  overlap_viol = 0, align_viol = 0, stab_viol = 0;
  int  stall_cfg = 0;
  bit  spurious = 1'b0;
  logic [63:0] backing [logic [31:0]];
  typedef struct {logic [31:0] addr; logic [63:0] data;} wb_t;
  wb_t wb_log[$];

  // Reference: the buffer must look like plain memory; line state predicts traffic.
  logic [31:0] gold [logic [31:0]];
  bit          ref_valid = 1'b0;
  bit          ref_dirty = 1'b0;
  logic [26:0] ref_tag   = '0;

  function automatic logic [31:0] init_word(logic [31:0] a);
    logic [3:0] n;
    if (a[31:5] == 27'd0) begin
      n = 4'(a[4:3]) + 4'd1;
      return {8{n}};
    end
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [63:0] backing_beat(logic [31:0] a);
    if (backing.exists(a)) return backing[a];
    return {init_word(a + 32'd4), init_word(a)};
  endfunction

  function automatic logic [31:0] gold_rd(logic [31:0] a);
    if (gold.exists(a)) return gold[a];
    return init_word(a);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_predict(input logic [31:0] addr, output int erd, output int ewr,
                               output int elat);
    if (ref_valid && ref_tag == addr[31:5]) begin
      erd = 0; ewr = 0; elat = 1;
    end else if (ref_valid && ref_dirty) begin
      erd = 4; ewr = 4; elat = 1 + 8 * (stall_cfg + 1);
    end else begin
      erd = 4; ewr = 0; elat = 1 + 4 * (stall_cfg + 1);
    end
  endtask

  task automatic model_apply(input bit wr, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wd);
    if (!(ref_valid && ref_tag == addr[31:5])) begin
      ref_valid = 1'b1;
      ref_tag   = addr[31:5];
      ref_dirty = 1'b0;
    end
    if (wr) begin
      ref_dirty = 1'b1;
      gold[{addr[31:2], 2'b00}] = merge(gold_rd({addr[31:2], 2'b00}), wd, be);
    end
  endtask

  // Burst memory responder, driven on the falling edge.
  initial begin
    bit          in_burst = 1'b0;
    bit          cur_kind = 1'b0;
    logic [31:0] cur_addr = '0;
    int          beats = 0;
    int          stall_left = 0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.pmem_read && bus.pmem_write) overlap_viol++;
      if (!(bus.pmem_read || bus.pmem_write)) begin
        in_burst      = 1'b0;
        beats         = 0;
        bus.pmem_resp = spurious;
      end else begin
        if (bus.pmem_address[4:0] != 5'd0) align_viol++;
        if (in_burst && beats < 4 &&
            (bus.pmem_write != cur_kind || bus.pmem_address != cur_addr)) stab_viol++;
        if (!in_burst || beats == 4 || bus.pmem_write != cur_kind ||
            bus.pmem_address != cur_addr) begin
          in_burst   = 1'b1;
          beats      = 0;
          cur_kind   = bus.pmem_write;
          cur_addr   = bus.pmem_address;
          stall_left = stall_cfg;
        end
        if (stall_left > 0) begin
          bus.pmem_resp = 1'b0;
          stall_left--;
        end else begin
          bus.pmem_resp = 1'b1;
          if (cur_kind) begin
            backing[cur_addr + 32'(8 * beats)] = bus.pmem_wdata;
            wb_log.push_back('{cur_addr + 32'(8 * beats), bus.pmem_wdata});
            wr_total++;
          end else begin
            bus.pmem_rdata = backing_beat(cur_addr + 32'(8 * beats));
            rd_total++;
          end
          beats++;
          stall_left = stall_cfg;
        end
      end
    end
  end

  task automatic do_op(input bit wr, input bit rd, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd,
                       output logic [31:0] rdata, output int lat, output int nrd,
                       output int nwr);
    int rd0, wr0;
    bit got;
    rd0 = rd_total; wr0 = wr_total; got = 1'b0; lat = 0; rdata = '0;
    @(negedge clk);
    bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = addr;
    bus.mem_byte_enable = be; bus.mem_wdata = wd;
    while (!got && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (bus.mem_resp) begin
        got   = 1'b1;
        rdata = bus.mem_rdata;
      end
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL resp_timeout: no mem_resp after %0d cycles, required within 1000", lat);
    end
    // Request stays up through the edge that ends RESP, then drops.
    @(negedge clk);
    check("resp_one_cycle", bus.mem_resp, 0);
    bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    nrd = rd_total - rd0;
    nwr = wr_total - wr0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_rd;
    logic [31:0] exp_rd;
    int          exp_rdb;
    int          exp_wrb;
    int          exp_lat;
  } vec_t;

  vec_t tbl[6];

  initial begin
    logic [31:0] rdata, exp_rd;
    int lat, nrd, nwr, erd, ewr, elat, guard, rd0;
    logic [31:0] lines[5];

    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = '0;
    bus.mem_byte_enable = '0; bus.mem_wdata = '0;

    #2;
    check("rst_mem_resp", bus.mem_resp, 0);
    check("rst_mem_rdata", bus.mem_rdata, 0);
    check("rst_pmem_read", bus.pmem_read, 0);
    check("rst_pmem_write", bus.pmem_write, 0);
    check("rst_pmem_address", bus.pmem_address, 0);
    check("rst_pmem_wdata", bus.pmem_wdata, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    tbl[0] = '{1'b0, 32'h10, 4'h0, 32'h0, 1'b1, 32'h3333_3333, 4, 0, 5};
    tbl[1] = '{1'b0, 32'h14, 4'h0, 32'h0, 1'b1, 32'h3333_3333, 0, 0, 1};
    tbl[2] = '{1'b1, 32'h00, 4'b0011, 32'hDEAD_BEEF, 1'b0, 32'h0, 0, 0, 1};
    tbl[3] = '{1'b0, 32'h00, 4'h0, 32'h0, 1'b1, 32'h1111_BEEF, 0, 0, 1};
    tbl[4] = '{1'b0, 32'h100, 4'h0, 32'h0, 1'b1, init_word(32'h100), 4, 4, 9};
    tbl[5] = '{1'b0, 32'h104, 4'h0, 32'h0, 1'b1, init_word(32'h104), 0, 0, 1};

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].wr, !tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wdata, rdata, lat, nrd, nwr);
      if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rd);
      check($sformatf("vec%0d_fill_beats", i), nrd, tbl[i].exp_rdb);
      check($sformatf("vec%0d_wb_beats", i), nwr, tbl[i].exp_wrb);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
      model_apply(tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wdata);
      if (i == 4) begin
        check("wb_log_size", wb_log.size(), 4);
        if (wb_log.size() > 0) begin
          check("wb_first_addr", wb_log[0].addr, 32'h0);
          check("wb_first_data", wb_log[0].data, 64'h1111_1111_1111_BEEF);
        end
      end
    end

    // Stray pmem_resp while idle or responding must not disturb a hit.
    spurious = 1'b1;
    do_op(1'b0, 1'b1, 32'h108, 4'h0, 32'h0, rdata, lat, nrd, nwr);
    spurious = 1'b0;
    check("spurious_rdata", rdata, gold_rd(32'h108));
    check("spurious_latency", lat, 1);

    // Reset two beats into a fill abandons it; the next access refetches in full.
    rd0 = rd_total;
    guard = 0;
    @(negedge clk);
    bus.mem_read = 1'b1; bus.mem_address = 32'h200;
    while (rd_total - rd0 < 2 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("rst_reach_beat2", rd_total - rd0, 2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_mid_pmem_read", bus.pmem_read, 0);
    check("rst_mid_pmem_address", bus.pmem_address, 0);
    check("rst_mid_mem_resp", bus.mem_resp, 0);
    bus.mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    ref_valid = 1'b0;
    ref_dirty = 1'b0;
    do_op(1'b0, 1'b1, 32'h200, 4'h0, 32'h0, rdata, lat, nrd, nwr);
    check("post_rst_fill_beats", nrd, 4);
    check("post_rst_latency", lat, 5);
    check("post_rst_rdata", rdata, gold_rd(32'h200));
    model_apply(1'b0, 32'h200, 4'h0, 32'h0);

    // Slow memory: ten idle cycles ahead of every beat.
    stall_cfg = 10;
    do_op(1'b0, 1'b1, 32'h31C, 4'h0, 32'h0, rdata, lat, nrd, nwr);
    check("stall_fill_beats", nrd, 4);
    check("stall_latency", lat, 45);
    check("stall_rdata", rdata, gold_rd(32'h31C));
    model_apply(1'b0, 32'h31C, 4'h0, 32'h0);

    lines = '{32'h0, 32'h100, 32'h200, 32'h300, 32'h1000};
    for (int i = 0; i < 200; i++) begin
      logic [31:0] addr, wd;
      logic [3:0]  be;
      int op;
      stall_cfg = $urandom_range(0, 2);
      addr = lines[$urandom_range(0, 4)] + 32'(4 * $urandom_range(0, 7));
      op   = $urandom_range(0, 3);
      be   = 4'($urandom);
      wd   = $urandom;
      model_predict(addr, erd, ewr, elat);
      exp_rd = gold_rd(addr);
      do_op(op >= 2, op != 2, addr, be, wd, rdata, lat, nrd, nwr);
      if (op < 2) check($sformatf("rnd%0d_rdata", i), rdata, exp_rd);
      check($sformatf("rnd%0d_fill_beats", i), nrd, erd);
      check($sformatf("rnd%0d_wb_beats", i), nwr, ewr);
      check($sformatf("rnd%0d_latency", i), lat, elat);
      model_apply(op >= 2, addr, be, wd);
    end

    check("pmem_rw_overlap", overlap_viol, 0);
    check("pmem_addr_align", align_viol, 0);
    check("pmem_burst_stable", stab_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
